// File: rtl/merger_tree_n.sv
// LEAVES-way merge tree: binary merge nodes in heap order with 2-entry couplers
// between levels; merges ascending runs terminated by an all-zero record.
module merger_tree_n #(
   parameter int LEAVES     = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LEVELS     = $clog2(LEAVES)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [LEAVES*DATA_WIDTH-1:0] i_fifo,
   input  logic [LEAVES-1:0]            i_fifo_empty,
   input  logic                         i_fifo_out_ready,
   output logic [LEAVES-1:0]            o_fifo_read,
   output logic                         o_out_fifo_write,
   output logic [DATA_WIDTH-1:0]        o_data
);

   // Heap numbering: node n (1 = root) reads sources 2n and 2n+1. Sources
   // 2..LEAVES-1 are couplers (coupler c is written by node c); sources
   // LEAVES..2*LEAVES-1 are the leaf FIFO heads.
   localparam int SRCS = 2 << LEVELS;

   logic [DATA_WIDTH-1:0] src_data  [SRCS];
   logic [SRCS-1:2]       src_valid;
   logic [SRCS-1:2]       src_pop;
   logic [LEAVES-1:1]     push;
   logic [DATA_WIDTH-1:0] push_data [LEAVES];

   logic [DATA_WIDTH-1:0] cq_d0  [LEAVES];
   logic [DATA_WIDTH-1:0] cq_d1  [LEAVES];
   logic [1:0]            cq_cnt [LEAVES];

   // Handshake: a source is popped only when its valid is high and the node
   // fires; a node fires only when both sources are valid and downstream is
   // ready (coupler not full, or being dequeued in the same cycle).
   function automatic void node_step(
      input  logic [DATA_WIDTH-1:0] a,
      input  logic [DATA_WIDTH-1:0] b,
      input  logic                  va,
      input  logic                  vb,
      input  logic                  ready,
      output logic                  pop_a,
      output logic                  pop_b,
      output logic                  emit,
      output logic [DATA_WIDTH-1:0] rec
   );
      pop_a = 1'b0;
      pop_b = 1'b0;
      emit  = 1'b0;
      rec   = '0;
      if (va && vb && ready) begin
         emit = 1'b1;
         if (a == '0 && b == '0) begin
            pop_a = 1'b1;
            pop_b = 1'b1;
         end else if (a == '0 || (b != '0 && b < a)) begin
            pop_b = 1'b1;
            rec   = b;
         end else begin
            pop_a = 1'b1;
            rec   = a;
         end
      end
   endfunction

   always_comb begin
      logic pa, pb, em;
      logic [DATA_WIDTH-1:0] rc;
      pa        = 1'b0;
      pb        = 1'b0;
      em        = 1'b0;
      rc        = '0;
      src_valid = '0;
      src_pop   = '0;
      push      = '0;
      for (int i = 0; i < SRCS; i++) src_data[i] = '0;
      for (int i = 0; i < LEAVES; i++) push_data[i] = '0;
      for (int k = 0; k < LEAVES; k++) begin
         src_data[LEAVES+k]  = i_fifo[k*DATA_WIDTH +: DATA_WIDTH];
         src_valid[LEAVES+k] = ~i_fifo_empty[k];
      end
      for (int c = 2; c < LEAVES; c++) begin
         src_data[c]  = cq_d0[c];
         src_valid[c] = (cq_cnt[c] != 2'd0);
      end
      node_step(src_data[2], src_data[3], src_valid[2], src_valid[3],
                i_fifo_out_ready && !i_rst, pa, pb, em, rc);
      src_pop[2]   = pa;
      src_pop[3]   = pb;
      push[1]      = em;
      push_data[1] = rc;
      // Parents precede children in this loop, so src_pop[n] is already final.
      for (int n = 2; n < LEAVES; n++) begin
         node_step(src_data[2*n], src_data[2*n+1], src_valid[2*n], src_valid[2*n+1],
                   ((cq_cnt[n] != 2'd2) || src_pop[n]) && !i_rst, pa, pb, em, rc);
         src_pop[2*n]   = pa;
         src_pop[2*n+1] = pb;
         push[n]        = em;
         push_data[n]   = rc;
      end
   end

   assign o_fifo_read = src_pop[SRCS-1:LEAVES];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_out_fifo_write <= 1'b0;
         o_data           <= '0;
         for (int c = 2; c < LEAVES; c++) cq_cnt[c] <= 2'd0;
      end else begin
         o_out_fifo_write <= push[1];
         if (push[1]) o_data <= push_data[1];
         for (int c = 2; c < LEAVES; c++) begin
            case ({push[c], src_pop[c]})
               2'b10: begin
                  if (cq_cnt[c] == 2'd0) cq_d0[c] <= push_data[c];
                  else                   cq_d1[c] <= push_data[c];
                  cq_cnt[c] <= cq_cnt[c] + 2'd1;
               end
               2'b01: begin
                  cq_d0[c]  <= cq_d1[c];
                  cq_cnt[c] <= cq_cnt[c] - 2'd1;
               end
               2'b11: begin
                  if (cq_cnt[c] == 2'd2) begin
                     cq_d0[c] <= cq_d1[c];
                     cq_d1[c] <= push_data[c];
                  end else begin
                     cq_d0[c] <= push_data[c];
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
